// File: rtl/timer_pkg.sv
// Shared encodings and digit limits for the MM:SS BCD countdown timer.
package timer_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t RUN   = 2'd1;
  localparam state_t PAUSE = 2'd2;
  localparam state_t DONE  = 2'd3;

  localparam logic [3:0] BCD_MAX      = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;

  // Clamp an incoming nibble to the legal range of its digit position.
  function automatic logic [3:0] clamp_digit(input logic [3:0] val, input logic [3:0] max);
    return (val > max) ? max : val;
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD down-counting digit with wrap-to-MAX and a borrow output for chaining.
module bcd_digit_down
  import timer_pkg::*;
#(
  parameter logic [3:0] MAX = BCD_MAX
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear_val,
  input  logic       load_en,
  input  logic [3:0] load_val,
  input  logic       dec_en,
  output logic [3:0] digit,
  output logic       borrow_out
);

  // Priority: clear, then load, then decrement.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit <= 4'd0;
    end else if (clear_val) begin
      digit <= 4'd0;
    end else if (load_en) begin
      digit <= clamp_digit(load_val, MAX);
    end else if (dec_en) begin
      digit <= (digit == 4'd0) ? MAX : digit - 4'd1;
    end
  end

  assign borrow_out = dec_en && (digit == 4'd0);

endmodule

// File: rtl/bcd_countdown_timer.sv
// MM:SS countdown timer: 1 s prescaler, load/start/stop control FSM and a
// borrow-chained BCD decrement driving four seven-segment digit nibbles.
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int TICK_DIV = 50000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        load,
  input  logic [15:0] load_value,
  input  logic        start,
  input  logic        stop,
  output logic [3:0]  dig3,
  output logic [3:0]  dig2,
  output logic [3:0]  dig1,
  output logic [3:0]  dig0,
  output logic        running,
  output logic        done,
  output logic        expired,
  output logic [1:0]  state_dbg
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  // Handshake note: start/stop are plain levels sampled every cycle; there is
  // no valid/ready pairing. clear and load are single-cycle commands that
  // override everything else in the cycle they are seen.

  state_t        state;
  state_t        state_next;
  logic [PW-1:0] presc;
  logic          tick;
  logic          zero_hit;
  logic          count_nonzero;
  logic          go;
  logic          halt;
  logic          borrow0;
  logic          borrow1;
  logic          borrow2;
  logic          borrow3_unused;

  assign go            = start && !stop;
  assign halt          = stop && !start;
  assign tick          = (state == RUN) && (presc == PRESC_LAST);
  assign count_nonzero = |{dig3, dig2, dig1, dig0};
  // The decrement lands on 00:00 exactly when the count is 00:01 at a tick.
  assign zero_hit      = tick && ({dig3, dig2, dig1, dig0} == 16'h0001);

  bcd_digit_down #(.MAX(BCD_MAX)) u_s0 (
    .clk(clk), .reset(reset), .clear_val(clear), .load_en(load),
    .load_val(load_value[3:0]), .dec_en(tick),
    .digit(dig0), .borrow_out(borrow0)
  );

  bcd_digit_down #(.MAX(SEC_TENS_MAX)) u_s1 (
    .clk(clk), .reset(reset), .clear_val(clear), .load_en(load),
    .load_val(load_value[7:4]), .dec_en(borrow0),
    .digit(dig1), .borrow_out(borrow1)
  );

  bcd_digit_down #(.MAX(BCD_MAX)) u_m0 (
    .clk(clk), .reset(reset), .clear_val(clear), .load_en(load),
    .load_val(load_value[11:8]), .dec_en(borrow1),
    .digit(dig2), .borrow_out(borrow2)
  );

  bcd_digit_down #(.MAX(BCD_MAX)) u_m1 (
    .clk(clk), .reset(reset), .clear_val(clear), .load_en(load),
    .load_val(load_value[15:12]), .dec_en(borrow2),
    .digit(dig3), .borrow_out(borrow3_unused)
  );

  // Prescaler advances only in RUN, so a pause keeps the partial second.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
    end else if (clear || load) begin
      presc <= '0;
    end else if (state == RUN) begin
      presc <= tick ? '0 : presc + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (clear || load) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE, PAUSE: if (go && count_nonzero) state_next = RUN;
        RUN: begin
          if (zero_hit)  state_next = DONE;
          else if (halt) state_next = PAUSE;
        end
        default: state_next = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      expired <= 1'b0;
    end else begin
      expired <= zero_hit && !clear && !load;
    end
  end

  always_comb begin
    running   = (state == RUN);
    done      = (state == DONE);
    state_dbg = state;
  end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Randomized and directed bench for bcd_countdown_timer against a seconds-based model.
module tb_bcd_countdown_timer;

  localparam int TICK_DIV = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clear = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_value = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [3:0]  dig3, dig2, dig1, dig0;
  logic        running, done, expired;
  logic [1:0]  state_dbg;

  bcd_countdown_timer #(.TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .reset(reset), .clear(clear), .load(load),
    .load_value(load_value), .start(start), .stop(stop),
    .dig3(dig3), .dig2(dig2), .dig1(dig1), .dig0(dig0),
    .running(running), .done(done), .expired(expired),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Count kept as total seconds; mode is a bench-local phase number.
  localparam int PH_STOPPED = 0, PH_COUNTING = 1, PH_HELD = 2, PH_FINISHED = 3;
  int m_secs, m_frac, m_phase;
  bit m_pulse;

  logic [18:0] exp_q[$];
  logic [18:0] dut_vec;
  assign dut_vec = {dig3, dig2, dig1, dig0, running, done, expired};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int load_secs(input logic [15:0] v);
    int m1, m0, s1, s0;
    m1 = min_int(int'(v[15:12]), 9);
    m0 = min_int(int'(v[11:8]), 9);
    s1 = min_int(int'(v[7:4]), 5);
    s0 = min_int(int'(v[3:0]), 9);
    return (m1 * 10 + m0) * 60 + s1 * 10 + s0;
  endfunction

  function automatic logic [18:0] model_vec();
    int mins, secs;
    logic [15:0] d;
    mins = m_secs / 60;
    secs = m_secs % 60;
    d = {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10)};
    return {d, m_phase == PH_COUNTING, m_phase == PH_FINISHED, m_pulse};
  endfunction

  task automatic model_reset();
    m_secs = 0; m_frac = 0; m_phase = PH_STOPPED; m_pulse = 0;
  endtask

  task automatic model_step(input bit c, input bit l, input logic [15:0] lv, input bit st, input bit sp);
    bit second_done;
    m_pulse = 0;
    if (c) begin
      m_secs = 0; m_frac = 0; m_phase = PH_STOPPED;
    end else if (l) begin
      m_secs = load_secs(lv); m_frac = 0; m_phase = PH_STOPPED;
    end else if (m_phase == PH_STOPPED || m_phase == PH_HELD) begin
      if (st && !sp && m_secs != 0) m_phase = PH_COUNTING;
    end else if (m_phase == PH_COUNTING) begin
      second_done = (m_frac == TICK_DIV - 1);
      m_frac = second_done ? 0 : m_frac + 1;
      if (second_done) m_secs = m_secs - 1;
      if (second_done && m_secs == 0) begin
        m_phase = PH_FINISHED; m_pulse = 1;
      end else if (sp && !st) begin
        m_phase = PH_HELD;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_cycle(input bit c, input bit l, input logic [15:0] lv, input bit st, input bit sp);
    @(negedge clk);
    clear = c; load = l; load_value = lv; start = st; stop = sp;
    @(posedge clk);
    model_step(c, l, lv, st, sp);
    exp_q.push_back(model_vec());
    #1;
    check_val("cycle", 32'(dut_vec), 32'(exp_q.pop_front()));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive_cycle(0, 0, 16'h0, 0, 0);
  endtask

  // Asserts reset between edges and checks the outputs before the next edge.
  task automatic do_reset();
    @(negedge clk);
    clear = 0; load = 0; start = 0; stop = 0;
    #2 reset = 1'b1;
    model_reset();
    #1;
    check_val("async_reset", 32'(dut_vec), 32'(model_vec()));
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    do_reset();
    check_val("reset_zero", 32'(dut_vec), 32'h0);

    // Borrow chain through seconds tens and minutes units.
    drive_cycle(0, 1, 16'h0102, 0, 0);
    drive_cycle(0, 0, 16'h0, 1, 0);
    idle_cycles(4);
    check_val("borrow_0101", 32'(dut_vec[18:3]), 32'h0101);
    idle_cycles(4);
    check_val("borrow_0100", 32'(dut_vec[18:3]), 32'h0100);
    idle_cycles(4);
    check_val("borrow_0059", 32'(dut_vec[18:3]), 32'h0059);

    // Expiry pulse and DONE hold with start ignored.
    drive_cycle(0, 1, 16'h0003, 0, 0);
    drive_cycle(0, 0, 16'h0, 1, 0);
    idle_cycles(12);
    check_val("expire_pulse", 32'(dut_vec), {13'h0, 19'h00003});
    drive_cycle(0, 0, 16'h0, 1, 0);
    check_val("expire_one_cycle", 32'(dut_vec), {13'h0, 19'h00002});
    for (int i = 0; i < 20; i++) drive_cycle(0, 0, 16'h0, (i % 3) == 0, (i % 5) == 0);
    check_val("done_hold", 32'(dut_vec), {13'h0, 19'h00002});

    // Pause keeps the partial second.
    drive_cycle(0, 1, 16'h0010, 0, 0);
    drive_cycle(0, 0, 16'h0, 1, 0);
    idle_cycles(1);
    drive_cycle(0, 0, 16'h0, 0, 1);
    idle_cycles(10);
    check_val("pause_frozen", 32'(dut_vec[18:2]), {16'h0010, 1'b0});
    drive_cycle(0, 0, 16'h0, 1, 0);
    idle_cycles(1);
    check_val("pause_pre_tick", 32'(dut_vec[18:3]), 32'h0010);
    idle_cycles(1);
    check_val("pause_resume", 32'(dut_vec[18:3]), 32'h0009);

    // Sanitization and start-at-zero.
    drive_cycle(0, 1, 16'hAF7C, 0, 0);
    check_val("sanitize", 32'(dut_vec[18:3]), 32'h9959);
    drive_cycle(0, 1, 16'h0000, 0, 0);
    drive_cycle(0, 0, 16'h0, 1, 0);
    idle_cycles(2);
    check_val("zero_start", 32'(running), 32'h0);

    // Priority: clear beats load and start; load beats a coincident tick.
    drive_cycle(0, 1, 16'h0200, 0, 0);
    drive_cycle(1, 1, 16'h1234, 1, 0);
    check_val("prio_clear", 32'(dut_vec), 32'h0);
    drive_cycle(0, 1, 16'h0010, 0, 0);
    drive_cycle(0, 0, 16'h0, 1, 0);
    idle_cycles(3);
    drive_cycle(0, 1, 16'h0500, 0, 0);
    check_val("prio_load_tick", 32'(dut_vec[18:2]), {16'h0500, 1'b0});

    // Reset mid-RUN acts between clock edges.
    drive_cycle(0, 1, 16'h0130, 0, 0);
    drive_cycle(0, 0, 16'h0, 1, 0);
    idle_cycles(6);
    check_val("pre_reset_run", 32'(running), 32'h1);
    do_reset();
    check_val("mid_run_reset", 32'(dut_vec), 32'h0);

    // Randomized control traffic.
    for (int i = 0; i < 3000; i++) begin
      bit c, l, st, sp;
      logic [15:0] lv;
      c  = ($urandom_range(0, 99) == 0);
      l  = ($urandom_range(0, 39) == 0);
      st = ($urandom_range(0, 3) == 0);
      sp = ($urandom_range(0, 11) == 0);
      lv = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 65535))
                                       : {12'h000, 4'($urandom_range(0, 9))};
      if ($urandom_range(0, 499) == 0) do_reset();
      else drive_cycle(c, l, lv, st, sp);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- Sequential MM:SS countdown timer that produces the four BCD nibbles consumed directly by the per-digit HEX seven-segment decoders.
- Used for the volcano eruption and operation countdowns.
- Contains a cycle prescaler, a load/start/stop control FSM and a borrow-chained BCD decrement.
- Output digits are registered and always valid BCD.

Parameters:
- TICK_DIV, 50000000, number of clk cycles per 1-second tick; must be ≥2 (benches use 4).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous: zero the count and return to IDLE.
- load  input  1  synchronous: load load_value and return to IDLE.
- load_value  input  16  BCD {m1,m0,s1,s0}; [15:12]=minutes tens, [3:0]=seconds units.
- start  input  1  level; begin or resume counting.
- stop  input  1  level; pause counting.
- dig3  output  4  minutes tens (0-9).
- dig2  output  4  minutes units (0-9).
- dig1  output  4  seconds tens (0-5).
- dig0  output  4  seconds units (0-9).
- running  output  1  high while in RUN.
- done  output  1  high while in DONE.
- expired  output  1  one-cycle pulse when the count reaches 00:00.

Behaviour:
- Reset (async): dig0-3=0, state IDLE, prescaler=0, running=0, done=0, expired=0. Reset asserted mid-RUN takes effect immediately, without waiting for a clock edge.
- States: IDLE, RUN, PAUSE, DONE. running = (state==RUN); done = (state==DONE). Both are registered, i.e. derived from the state register.
- Control priority per cycle: clear > load > start/stop.
- clear (any state): digits←0, prescaler←0, state←IDLE.
- load (any state): digits←sanitized load_value, prescaler←0, state←IDLE.
- Sanitization, per nibble: m1, m0, s0 >9 → 9; s1 >5 → 5.
- start and stop asserted together: no effect.
- IDLE/PAUSE + start (stop low):
  - count ≠ 00:00 → RUN next cycle.
  - count = 00:00 → ignored.
- RUN + stop (start low) → PAUSE. The prescaler value is retained, so time already accrued in the current second is preserved.
- DONE: start/stop ignored; exit only via clear, load or reset.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN; frozen in every other state.
  - tick = RUN && prescaler==TICK_DIV-1; the prescaler wraps to 0 on the tick.
  - First tick after IDLE→RUN occurs TICK_DIV cycles after entering RUN.
- Decrement on tick (registered; new digits visible the cycle after the tick edge):
  - s0 decrements; s0 0→9 borrows into s1.
  - s1 0→5 borrows into m0.
  - m0 0→9 borrows into m1.
  - m1 never underflows, because 00:00 exits RUN.
- Zero reached (decrement result = 00:00): state←DONE and expired←1 in the same update. expired is high exactly one cycle, coincident with the first cycle digits read 00:00.
- Tick and stop in the same cycle: the decrement is applied. State←PAUSE, unless the result is 00:00, in which case DONE wins.
- Tick and clear/load in the same cycle: clear/load wins; no decrement.
- Digits never leave the BCD ranges above under any sequence.

Decomposition:
- Shared package (timer_pkg):
  - state encoding localparams IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3.
  - BCD_MAX=4'd9, SEC_TENS_MAX=4'd5.
- One natural sub-module: bcd_digit_down.
  - Parameter MAX.
  - Inputs: clk, reset, clear_val, load_en, load_val, dec_en.
  - Outputs: digit, borrow_out. borrow_out = dec_en && digit==0.
  - Instantiated four times in a borrow chain.
- Prescaler and FSM stay in the top module.

Test Plan (TICK_DIV=4):
- Reset mid-RUN: load 0x0130, start, after 6 cycles assert reset → dig3..0=0, running=0, done=0 immediately, before the next clock edge.
- Borrow chain: load 0x0102, start → 01:01, 01:00, 00:59 on successive ticks exactly 4 cycles apart; 00:59 visible the cycle after the third tick.
- Expiry: load 0x0003, start → expired high exactly 1 cycle together with first 00:00; done=1 and digits hold for 20 further cycles; start ignored.
- Pause retention: load 0x0010, start, stop after 2 RUN cycles, hold 10 cycles (digits 00:10 frozen), start → 00:09 appears after 2 more RUN cycles.
- Sanitization: load 0xAF7C → 99:59; load 0x0000, start → stays IDLE, running=0.
- Priority: clear, load (0x1234) and start in the same cycle → 00:00, IDLE. Tick coincident with load 0x0500 → 05:00, no decrement.
